tlul_rsp_intg_chk_buf: RTL and testbench

TLUL_RSP_INTG_CHK_BUF -- requirements
Module: tlul_rsp_intg_chk_buf

---
 rtl/tlul_rsp_intg_chk_buf.sv | 171 +++++++++++++++++
 tb/tb_tlul_rsp_intg_chk_buf.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_rsp_intg_chk_buf.sv
// TL-UL D-channel response buffer: SECDED integrity check on entry, 2-deep FIFO, 1-cycle latency.
// Upstream ready depends only on registered occupancy; beats failing integrity leave with d_error=1 and data zeroed.
`timescale 1ns/1ps
package tlul_rsp_intg_pkg;
  localparam int unsigned D2HRspMaxWidth = 57;
  localparam int unsigned DataMaxWidth   = 32;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic       d_valid;
    tl_d_op_e   d_opcode;
    logic [2:0] d_param;
    logic [1:0] d_size;
    logic [7:0] d_source;
    logic [0:0] d_sink;
    logic [31:0] d_data;
    tl_d_user_t d_user;
    logic       d_error;
    logic       a_ready;
  } tl_d2h_t;

  typedef struct packed {
    tl_d_op_e   opcode;
    logic [1:0] size;
    logic       error;
  } tl_d2h_rsp_intg_t;

  localparam tl_d2h_t TL_D2H_DEFAULT = '{
    d_valid:  1'b0,
    d_opcode: AccessAck,
    d_param:  '0,
    d_size:   '0,
    d_source: '0,
    d_sink:   '0,
    d_data:   '0,
    d_user:   '0,
    d_error:  1'b0,
    a_ready:  1'b1
  };

  function automatic tl_d2h_rsp_intg_t extract_d2h_rsp_intg(input tl_d2h_t tl);
    tl_d2h_rsp_intg_t r;
    r.opcode = tl.d_opcode;
    r.size   = tl.d_size;
    r.error  = tl.d_error;
    return r;
  endfunction

  // Hsiao (64,57) check bits; data occupies the low 57 bits of the codeword.
  function automatic logic [6:0] secded_64_57_chk(input logic [D2HRspMaxWidth-1:0] d);
    logic [6:0] c;
    c[0] = ^(d & 57'h103FFF800007FFF);
    c[1] = ^(d & 57'h17C1FF801FF801F);
    c[2] = ^(d & 57'h1BDE1F87E0781E1);
    c[3] = ^(d & 57'h1DEEE3B8E388E22);
    c[4] = ^(d & 57'h1EF76CDB2C93244);
    c[5] = ^(d & 57'h1F7BB56D5525488);
    c[6] = ^(d & 57'h1FBDDA769A46910);
    return c;
  endfunction
endpackage

module tlul_rsp_intg_chk_buf
  import tlul_rsp_intg_pkg::*;
#(
  parameter bit          EnableRspIntgChk  = 1'b1,
  parameter bit          EnableDataIntgChk = 1'b1,
  parameter int unsigned ErrCntWidth       = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  tl_d2h_t                tl_i,
  output logic                   d_ready_o,
  output tl_d2h_t                tl_o,
  input  logic                   d_ready_i,
  output logic                   intg_err_o,
  output logic                   intg_err_pulse_o,
  output logic [ErrCntWidth-1:0] err_cnt_o
);

  logic [1:0]             r_count;
  logic                   r_wptr;
  logic                   r_rptr;
  tl_d2h_t                r_mem [2];
  logic [1:0]             r_err;
  logic                   r_err_sticky;
  logic                   r_err_pulse;
  logic [ErrCntWidth-1:0] r_err_cnt;

  logic       w_enq;
  logic       w_deq;
  logic [6:0] w_rsp_chk;
  logic [6:0] w_data_chk;
  logic       w_rsp_err;
  logic       w_data_err;
  logic       w_beat_err;

  assign w_rsp_chk  = secded_64_57_chk(D2HRspMaxWidth'(extract_d2h_rsp_intg(tl_i)));
  assign w_data_chk = secded_64_57_chk(D2HRspMaxWidth'(DataMaxWidth'(tl_i.d_data)));
  assign w_rsp_err  = EnableRspIntgChk  && (w_rsp_chk  != tl_i.d_user.rsp_intg);
  assign w_data_err = EnableDataIntgChk && (w_data_chk != tl_i.d_user.data_intg);
  assign w_beat_err = w_rsp_err | w_data_err;

  assign d_ready_o = (r_count != 2'd2);
  assign w_enq     = tl_i.d_valid & d_ready_o;
  assign w_deq     = tl_o.d_valid & d_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_enq) r_wptr <= ~r_wptr;
      if (w_deq) r_rptr <= ~r_rptr;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never observed while empty, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wptr] <= tl_i;
      r_err[r_wptr] <= w_beat_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_sticky <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_err_pulse <= w_enq & w_beat_err;
      if (w_enq && w_beat_err) begin
        r_err_sticky <= 1'b1;
        if (r_err_cnt != {ErrCntWidth{1'b1}}) r_err_cnt <= r_err_cnt + ErrCntWidth'(1);
      end
    end
  end

  always_comb begin
    tl_o = TL_D2H_DEFAULT;
    if (r_count != 2'd0) begin
      tl_o         = r_mem[r_rptr];
      tl_o.d_valid = 1'b1;
      if (r_err[r_rptr]) begin
        tl_o.d_error = 1'b1;
        tl_o.d_data  = '0;
      end
    end
  end

  assign intg_err_o       = r_err_sticky;
  assign intg_err_pulse_o = r_err_pulse;
  assign err_cnt_o        = r_err_cnt;

endmodule

// File: tb/tb_tlul_rsp_intg_chk_buf.sv
// Scoreboard bench for tlul_rsp_intg_chk_buf: directed beats push expected outputs, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_tlul_rsp_intg_chk_buf;
  import tlul_rsp_intg_pkg::*;

  localparam logic [56:0] MASKS [7] = '{
    57'h103FFF800007FFF, 57'h17C1FF801FF801F, 57'h1BDE1F87E0781E1, 57'h1DEEE3B8E388E22,
    57'h1EF76CDB2C93244, 57'h1F7BB56D5525488, 57'h1FBDDA769A46910
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  tl_d2h_t    tl_in, tl_out, tl_in_nr, tl_out_nr;
  logic       rdy_in, rdy_out, rdy_in_nr, rdy_out_nr;
  logic       err, pulse, err_nr, pulse_nr;
  logic [7:0] cnt, cnt_nr;
  int         n_checks = 0;
  int         n_errors = 0;
  tl_d2h_t    exp_q [$];

  always #5 clk = ~clk;

  tlul_rsp_intg_chk_buf dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_in), .d_ready_o(rdy_out), .tl_o(tl_out),
    .d_ready_i(rdy_in), .intg_err_o(err), .intg_err_pulse_o(pulse), .err_cnt_o(cnt)
  );

  tlul_rsp_intg_chk_buf #(.EnableRspIntgChk(1'b0)) dut_nr (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(tl_in_nr), .d_ready_o(rdy_out_nr), .tl_o(tl_out_nr),
    .d_ready_i(rdy_in_nr), .intg_err_o(err_nr), .intg_err_pulse_o(pulse_nr), .err_cnt_o(cnt_nr)
  );

  function automatic logic [6:0] tb_secded(input logic [56:0] d);
    logic [6:0] c = '0;
    for (int k = 0; k < 7; k++)
      for (int b = 0; b < 57; b++)
        if (MASKS[k][b]) c[k] = c[k] ^ d[b];
    return c;
  endfunction

  function automatic tl_d2h_t mk_beat(input logic [31:0] data, input logic [7:0] src,
                                      input tl_d_op_e op, input logic derr);
    tl_d2h_t b;
    b.d_valid  = 1'b1;
    b.d_opcode = op;
    b.d_param  = 3'd0;
    b.d_size   = 2'd2;
    b.d_source = src;
    b.d_sink   = 1'b0;
    b.d_data   = data;
    b.d_error  = derr;
    b.a_ready  = 1'b1;
    b.d_user.rsp_intg  = tb_secded(57'({op, 2'd2, derr}));
    b.d_user.data_intg = tb_secded(57'(data));
    return b;
  endfunction

  function automatic tl_d2h_t exp_of(input tl_d2h_t b, input logic bad);
    tl_d2h_t e = b;
    e.d_valid = 1'b1;
    if (bad) begin
      e.d_error = 1'b1;
      e.d_data  = 32'h0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic offer(input tl_d2h_t b, input logic bad, output int waited);
    waited = 0;
    tl_in = b;
    while (!rdy_out && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!rdy_out) begin
      n_checks++;
      n_errors++;
      $display("FAIL offer_timeout: ready stayed %0b expected 1", rdy_out);
      tl_in.d_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp_of(b, bad));
    @(posedge clk); #1;
    tl_in.d_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tl_out.d_valid && rdy_in) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got %0h expected none", tl_out);
        end else begin
          tl_d2h_t e;
          e = exp_q.pop_front();
          check("beat", 128'(tl_out), 128'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int      w;
    tl_d2h_t b;
    tl_d2h_t def_exp;
    def_exp = '0;
    def_exp.a_ready = 1'b1;
    tl_in = '0; tl_in_nr = '0; rdy_in = 1'b0; rdy_in_nr = 1'b1;
    #12;
    check("rst_ready", 128'(rdy_out), 128'(1'b1));
    check("rst_valid", 128'(tl_out.d_valid), 128'(1'b0));
    check("rst_err", 128'(err), 128'(1'b0));
    check("rst_pulse", 128'(pulse), 128'(1'b0));
    check("rst_cnt", 128'(cnt), 128'(8'd0));
    check("rst_tl_default", 128'(tl_out), 128'(def_exp));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean beat, one-cycle latency
    rdy_in = 1'b1;
    offer(mk_beat(32'hDEADBEEF, 8'h01, AccessAckData, 1'b0), 1'b0, w);
    check("clean_valid", 128'(tl_out.d_valid), 128'(1'b1));
    check("clean_data", 128'(tl_out.d_data), 128'(32'hDEADBEEF));
    check("clean_derr", 128'(tl_out.d_error), 128'(1'b0));
    check("clean_cnt", 128'(cnt), 128'(8'd0));
    @(posedge clk); #1;

    // Backpressure: two accepted, third stalls until a dequeue frees a slot
    rdy_in = 1'b0;
    offer(mk_beat(32'h0000000A, 8'h02, AccessAckData, 1'b0), 1'b0, w);
    offer(mk_beat(32'h0000000B, 8'h03, AccessAckData, 1'b0), 1'b0, w);
    tl_in = mk_beat(32'h0000000C, 8'h04, AccessAckData, 1'b0);
    check("full_ready_low", 128'(rdy_out), 128'(1'b0));
    @(posedge clk); #1;
    check("full_ready_held", 128'(rdy_out), 128'(1'b0));
    rdy_in = 1'b1;
    offer(mk_beat(32'h0000000C, 8'h04, AccessAckData, 1'b0), 1'b0, w);
    check("full_no_same_cycle_enq", 128'(w), 128'(1));
    drain();

    // Data integrity error
    b = mk_beat(32'h12345678, 8'h10, AccessAckData, 1'b0);
    b.d_user.data_intg[0] = ~b.d_user.data_intg[0];
    offer(b, 1'b1, w);
    check("derr_pulse", 128'(pulse), 128'(1'b1));
    check("derr_sticky", 128'(err), 128'(1'b1));
    check("derr_cnt", 128'(cnt), 128'(8'd1));
    check("derr_d_error", 128'(tl_out.d_error), 128'(1'b1));
    check("derr_d_data", 128'(tl_out.d_data), 128'(32'h0));
    @(posedge clk); #1;
    check("derr_pulse_one_cycle", 128'(pulse), 128'(1'b0));
    check("derr_sticky_held", 128'(err), 128'(1'b1));

    // Response integrity error, then a legitimate d_error beat that must pass clean
    b = mk_beat(32'h55AA55AA, 8'h11, AccessAck, 1'b0);
    b.d_user.rsp_intg[3] = ~b.d_user.rsp_intg[3];
    offer(b, 1'b1, w);
    check("rerr_cnt", 128'(cnt), 128'(8'd2));
    offer(mk_beat(32'hA5A5A5A5, 8'h12, AccessAckData, 1'b1), 1'b0, w);
    check("derr_field_clean_cnt", 128'(cnt), 128'(8'd2));

    // Back-to-back clean beats, no stalls
    for (int i = 0; i < 4; i++) begin
      offer(mk_beat(32'hF0000000 + 32'(i), 8'(8'h30 + i), AccessAckData, 1'b0), 1'b0, w);
      check("burst_no_stall", 128'(w), 128'(0));
    end

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) begin
      b = mk_beat(32'(i * 32'h01010101), 8'(i), AccessAckData, 1'b0);
      if (i % 2 == 0) b.d_user.data_intg = b.d_user.data_intg ^ 7'(1 << (i % 7));
      else            b.d_user.rsp_intg  = b.d_user.rsp_intg  ^ 7'(1 << (i % 7));
      offer(b, 1'b1, w);
      if (i == 251) check("sat_cnt_254", 128'(cnt), 128'(8'd254));
      if (i == 252) check("sat_cnt_255", 128'(cnt), 128'(8'd255));
    end
    check("sat_cnt_hold", 128'(cnt), 128'(8'd255));
    check("sat_sticky", 128'(err), 128'(1'b1));
    drain();

    // Response check disabled instance
    b = mk_beat(32'hCAFEF00D, 8'h20, AccessAckData, 1'b0);
    b.d_user.rsp_intg[2] = ~b.d_user.rsp_intg[2];
    tl_in_nr = b;
    @(posedge clk); #1;
    tl_in_nr.d_valid = 1'b0;
    check("nr_valid", 128'(tl_out_nr.d_valid), 128'(1'b1));
    check("nr_data", 128'(tl_out_nr.d_data), 128'(32'hCAFEF00D));
    check("nr_d_error", 128'(tl_out_nr.d_error), 128'(1'b0));
    check("nr_cnt", 128'(cnt_nr), 128'(8'd0));
    check("nr_pulse", 128'(pulse_nr), 128'(1'b0));
    @(posedge clk); #1;
    b = mk_beat(32'h0BADF00D, 8'h21, AccessAckData, 1'b0);
    b.d_user.data_intg[5] = ~b.d_user.data_intg[5];
    tl_in_nr = b;
    @(posedge clk); #1;
    tl_in_nr.d_valid = 1'b0;
    check("nr_data_chk_err", 128'(tl_out_nr.d_error), 128'(1'b1));
    check("nr_data_chk_cnt", 128'(cnt_nr), 128'(8'd1));

    // Asynchronous reset while full with the sticky flag set
    rdy_in = 1'b0;
    b = mk_beat(32'h11111111, 8'h40, AccessAckData, 1'b0);
    b.d_user.data_intg[1] = ~b.d_user.data_intg[1];
    offer(b, 1'b1, w);
    offer(mk_beat(32'h22222222, 8'h41, AccessAckData, 1'b0), 1'b0, w);
    check("pre_rst_full", 128'(rdy_out), 128'(1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(tl_out.d_valid), 128'(1'b0));
    check("arst_err", 128'(err), 128'(1'b0));
    check("arst_cnt", 128'(cnt), 128'(8'd0));
    check("arst_ready", 128'(rdy_out), 128'(1'b1));
    check("arst_pulse", 128'(pulse), 128'(1'b0));
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_default", 128'(tl_out), 128'(def_exp));
    rdy_in = 1'b1;
    offer(mk_beat(32'h33333333, 8'h42, AccessAckData, 1'b0), 1'b0, w);
    drain();
    @(posedge clk); #1;
    check("final_empty", 128'(tl_out.d_valid), 128'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
